uart_tx_mmio: RTL
=================

UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16: clk cycles per serial bit (legal 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: TX FIFO entries (power of 2, 2..64).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_1000: byte address of TXDATA; STATUS at BASE_ADDR+4.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port wen  input  1  core data-memory write request.
REQ-007 SHALL have port w_addr_i  input  32  write byte address.
REQ-008 SHALL have port w_data_i  input  32  write data; only [7:0] used.
REQ-009 SHALL have port ren  input  1  core data-memory read request.
REQ-010 SHALL have port r_addr_i  input  32  read byte address.
REQ-011 SHALL have port r_data_o  output  32  read data.
REQ-012 SHALL have port tx_o  output  1  serial line, idle high.
REQ-013 SHALL have port irq_o  output  1  high while FIFO empty and serializer IDLE.

Function
REQ-014 Push: wen && w_addr_i==BASE_ADDR pushes w_data_i[7:0] at the clock edge; other addresses ignored.
REQ-015 Push when full with no same-edge pop: data dropped, sticky overflow flag set; FIFO content unchanged.
REQ-016 Push when full with same-edge pop: push accepted, count unchanged.
REQ-017 Read combinational: ren && r_addr_i==BASE_ADDR+4 -> r_data_o = {20'b0, count[7:0] zero-extended to bits 11:4, overflow, busy, empty, full} (bit0 full, bit1 empty, bit2 busy, bit3 overflow); any other read -> 0.
REQ-018 Overflow cleared at the edge where a STATUS read occurs; a same-edge overflow event wins (flag stays 1).
REQ-019 FSM states IDLE, START, DATA, STOP (PARITY when enabled); busy = state != IDLE.
REQ-020 IDLE with FIFO non-empty: at next edge pop head into shift register, enter START, bit counter 0.
REQ-021 Each serial bit SHALL last exactly CLK_DIV cycles; tx_o registered: START=0, DATA=shift LSB first (8 bits), STOP=1.
REQ-022 End of STOP: if FIFO non-empty pop and enter START at same edge (no idle gap), else IDLE.
REQ-023 Frame length SHALL be 10*CLK_DIV cycles; first start-bit cycle begins 2 edges after the push edge when idle.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-025 Writes to TXDATA during transmission SHALL not disturb the frame in flight.

Reset
REQ-026 rst at any edge, including mid-frame: state IDLE, FIFO emptied, overflow 0, divider and bit counters 0, tx_o=1 next cycle; r_data_o reflects reset state (empty=1).
REQ-027 irq_o SHALL be 1 after reset; r_data_o 0 unless STATUS read.

Configuration
REQ-028 Macro UART_TX_PARITY_EN defined: PARITY state inserted between DATA and STOP, transmitting even parity (XOR of 8 data bits), frame 11*CLK_DIV cycles.
REQ-029 Macro undefined: no parity state, frame 10*CLK_DIV cycles, no parity logic present.

Verification
REQ-030 CLK_DIV=4, write 0x55 to BASE_ADDR -> tx_o low 4 cycles starting 2 edges later, then 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles, irq_o returns 1.
REQ-031 FIFO_DEPTH=8, 10 back-to-back writes while idle -> 9 bytes transmitted (one popped immediately), 10th dropped, STATUS bit3=1; STATUS read clears it next cycle.
REQ-032 Two bytes 0xA5,0x3C queued -> frames contiguous, no idle cycle between STOP and next START.
REQ-033 rst asserted during DATA bit 3 -> tx_o=1 next cycle, STATUS reads 0x002 (empty), no further frame.
REQ-034 Write 0x12 to BASE_ADDR+8 and read BASE_ADDR -> no push, r_data_o=0.
REQ-035 UART_TX_PARITY_EN defined, write 0x07 -> parity bit 1 after data, frame 44 cycles at CLK_DIV=4.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TXDATA push port, STATUS readback, TX FIFO, 8N1 serializer.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_mmio #(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wen,
    input  logic [31:0] w_addr_i,
    input  logic [31:0] w_data_i,
    input  logic        ren,
    input  logic [31:0] r_addr_i,
    output logic [31:0] r_data_o,
    output logic        tx_o,
    output logic        irq_o
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    state_e        r_state;
    logic [15:0]   r_div;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
`ifdef UART_TX_PARITY_EN
    logic          r_par;
`endif

    logic       w_push_req, w_push, w_pop, w_full, w_empty, w_bit_end, w_stat_rd;
    logic [7:0] w_head, w_count8;
    logic       w_unused_data;

    assign w_unused_data = ^w_data_i[31:8];
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_bit_end  = (r_div == 16'(CLK_DIV - 1));
    assign w_head     = r_mem[r_rptr];
    assign w_push_req = wen && (w_addr_i == BASE_ADDR);
    // Serializer pulls the head when idle or when a stop bit finishes.
    assign w_pop      = !w_empty && ((r_state == StIdle) || ((r_state == StStop) && w_bit_end));
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_stat_rd  = ren && (r_addr_i == BASE_ADDR + 32'd4);
    assign w_count8   = {{(8 - CW){1'b0}}, r_count};

    assign r_data_o = w_stat_rd ? {20'b0, w_count8, r_ovf, (r_state != StIdle), w_empty, w_full}
                                : 32'b0;
    assign tx_o     = r_tx;
    assign irq_o    = w_empty && (r_state == StIdle);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_data_i[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
            // A drop on the same edge as a STATUS read keeps the flag set.
            if (w_push_req && w_full && !w_pop) r_ovf <= 1'b1;
            else if (w_stat_rd)                 r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            // Line output follows the state one cycle later; every bit keeps CLK_DIV cycles.
            unique case (r_state)
                StStart: r_tx <= 1'b0;
                StData:  r_tx <= r_shift[0];
`ifdef UART_TX_PARITY_EN
                StParity: r_tx <= r_par;
`endif
                default: r_tx <= 1'b1;
            endcase
            r_div <= w_bit_end ? 16'd0 : r_div + 16'd1;
            unique case (r_state)
                StIdle: begin
                    r_div <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_bit   <= '0;
                        r_state <= StStart;
`ifdef UART_TX_PARITY_EN
                        r_par   <= ^w_head;
`endif
                    end
                end
                StStart: begin
                    if (w_bit_end) r_state <= StData;
                end
                StData: begin
                    if (w_bit_end) begin
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
`ifdef UART_TX_PARITY_EN
                        if (r_bit == 3'd7) r_state <= StParity;
`else
                        if (r_bit == 3'd7) r_state <= StStop;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (w_bit_end) r_state <= StStop;
                end
`endif
                StStop: begin
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_bit   <= '0;
                            r_state <= StStart;
`ifdef UART_TX_PARITY_EN
                            r_par   <= ^w_head;
`endif
                        end else begin
                            r_state <= StIdle;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end
endmodule
